// File: rtl/adder_pipe_mc_if.sv
// Request/result handshake bundle for the multi-channel add/sub/accumulate engine.
// The slave modport is the engine; the master modport is the producer/consumer side.
interface adder_pipe_mc_if #(
  parameter int WIDTH = 32,
  parameter int CHW   = 2
);
  logic             i_valid;
  logic             o_ready;
  logic [1:0]       i_op;
  logic [CHW-1:0]   i_ch;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_a;
  logic [CHW-1:0]   o_ch;
  logic             o_ovf;
  logic             o_err;

  modport slave (
    input  i_valid, i_op, i_ch, i_a, i_b, i_ready,
    output o_ready, o_valid, o_a, o_ch, o_ovf, o_err
  );

  modport master (
    output i_valid, i_op, i_ch, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_a, o_ch, o_ovf, o_err
  );
endinterface

// File: rtl/adder_pipe_mc.sv
// Two-stage signed add/sub/accumulate engine with per-channel accumulators.
// S1 holds the request; the result is computed on the S1->S2 move and S2 drives the output.
module adder_pipe_mc #(
  parameter int  WIDTH    = 32,
  parameter int  N_CH     = 4,
  parameter int  SATURATE = 0,
  localparam int CHW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  adder_pipe_mc_if.slave   bus
);
  localparam logic [CHW:0]     N_CH_W  = (CHW+1)'(N_CH);
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic             s1_v_reg;
  logic [1:0]       s1_op_reg;
  logic [CHW-1:0]   s1_ch_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;

  logic             s2_v_reg;
  logic [WIDTH-1:0] s2_a_reg;
  logic [CHW-1:0]   s2_ch_reg;
  logic             s2_ovf_reg;
  logic             s2_err_reg;

  logic             s2_load;
  logic             s1_adv;
  logic             ready;

  logic [WIDTH-1:0] acc_q [N_CH];
  logic [WIDTH-1:0] acc_cur;
  logic [WIDTH:0]   sum_x;
  logic             ch_ok;
  logic             ovf_raw;
  logic [WIDTH-1:0] res_sat;
  logic [WIDTH-1:0] res_a_next;
  logic             res_ovf_next;
  logic             res_err_next;
  logic [WIDTH-1:0] acc_next;

  assign s2_load = !s2_v_reg | bus.i_ready;
  assign s1_adv  = s1_v_reg & s2_load;
  // Held low while reset is asserted so nothing is accepted until release.
  assign ready   = i_arst_n & (!s1_v_reg | s2_load);

  assign bus.o_ready = ready;
  assign bus.o_valid = s2_v_reg;
  assign bus.o_a     = s2_a_reg;
  assign bus.o_ch    = s2_ch_reg;
  assign bus.o_ovf   = s2_ovf_reg;
  assign bus.o_err   = s2_err_reg;

  always_comb begin
    ch_ok        = ({1'b0, s1_ch_reg} < N_CH_W);
    acc_cur      = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (s1_ch_reg == CHW'(k)) acc_cur = acc_q[k];
    end
    unique case (s1_op_reg)
      2'b00:   sum_x = {s1_a_reg[WIDTH-1], s1_a_reg} + {s1_b_reg[WIDTH-1], s1_b_reg};
      2'b01:   sum_x = {s1_a_reg[WIDTH-1], s1_a_reg} - {s1_b_reg[WIDTH-1], s1_b_reg};
      2'b10:   sum_x = {acc_cur[WIDTH-1], acc_cur} + {s1_a_reg[WIDTH-1], s1_a_reg};
      default: sum_x = {acc_cur[WIDTH-1], acc_cur};
    endcase
    // The extra top bit disagrees with the sign bit exactly when the result overflows.
    ovf_raw = (s1_op_reg != 2'b11) && (sum_x[WIDTH] != sum_x[WIDTH-1]);
    if (SATURATE != 0 && ovf_raw) begin
      res_sat = sum_x[WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      res_sat = sum_x[WIDTH-1:0];
    end
    res_err_next = s1_op_reg[1] && !ch_ok;
    res_a_next   = res_err_next ? '0 : res_sat;
    res_ovf_next = ovf_raw && !res_err_next;
    acc_next     = (s1_op_reg == 2'b10) ? res_sat : '0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_acc
      logic [WIDTH-1:0] acc_reg;
      always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
          acc_reg <= '0;
        end else if (s1_adv && s1_op_reg[1] && s1_ch_reg == CHW'(gi)) begin
          acc_reg <= acc_next;
        end
      end
      assign acc_q[gi] = acc_reg;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      s1_v_reg  <= 1'b0;
      s1_op_reg <= '0;
      s1_ch_reg <= '0;
      s1_a_reg  <= '0;
      s1_b_reg  <= '0;
    end else if (ready) begin
      s1_v_reg <= bus.i_valid;
      if (bus.i_valid) begin
        s1_op_reg <= bus.i_op;
        s1_ch_reg <= bus.i_ch;
        s1_a_reg  <= bus.i_a;
        s1_b_reg  <= bus.i_b;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      s2_v_reg   <= 1'b0;
      s2_a_reg   <= '0;
      s2_ch_reg  <= '0;
      s2_ovf_reg <= 1'b0;
      s2_err_reg <= 1'b0;
    end else if (s2_load) begin
      s2_v_reg <= s1_v_reg;
      if (s1_v_reg) begin
        s2_a_reg   <= res_a_next;
        s2_ch_reg  <= s1_ch_reg;
        s2_ovf_reg <= res_ovf_next;
        s2_err_reg <= res_err_next;
      end
    end
  end
endmodule

// File: tb/tb_adder_pipe_mc.sv
// Directed bench: an 8-bit, 3-channel wrapping engine and a saturating twin driven in lockstep.
module tb_adder_pipe_mc;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  adder_pipe_mc_if #(.WIDTH(8), .CHW(2)) bus ();
  adder_pipe_mc_if #(.WIDTH(8), .CHW(2)) bus_s ();

  assign bus_s.i_valid = bus.i_valid;
  assign bus_s.i_op    = bus.i_op;
  assign bus_s.i_ch    = bus.i_ch;
  assign bus_s.i_a     = bus.i_a;
  assign bus_s.i_b     = bus.i_b;
  assign bus_s.i_ready = bus.i_ready;

  adder_pipe_mc #(.WIDTH(8), .N_CH(3), .SATURATE(0)) dut (
    .i_clk(clk), .i_arst_n(rst_n), .bus(bus)
  );
  adder_pipe_mc #(.WIDTH(8), .N_CH(3), .SATURATE(1)) dut_sat (
    .i_clk(clk), .i_arst_n(rst_n), .bus(bus_s)
  );

  logic [1:0] t_op [16];
  logic [1:0] t_ch [16];
  logic [7:0] t_a  [16];
  logic [7:0] t_b  [16];
  logic [7:0] t_ea [16];
  logic [7:0] t_es [16];
  logic       t_eo [16];
  logic       t_ee [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_t(input int i, input logic [1:0] op, input logic [1:0] ch,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] ea,
                       input logic eo, input logic ee, input logic [7:0] es);
    t_op[i] = op; t_ch[i] = ch; t_a[i] = a; t_b[i] = b;
    t_ea[i] = ea; t_eo[i] = eo; t_ee[i] = ee; t_es[i] = es;
  endtask

  // Single isolated op with i_ready high: checks two-cycle latency and all result fields.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [1:0] ch,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] ea,
                       input logic eo, input logic ee, input logic [7:0] es);
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_op = op; bus.i_ch = ch; bus.i_a = a; bus.i_b = b;
    #1 chk({tag, " ready"}, 32'(bus.o_ready), 32'd1);
    @(negedge clk);
    bus.i_valid = 1'b0;
    #1 chk({tag, " valid@+1"}, 32'(bus.o_valid), 32'd0);
    @(negedge clk);
    #1;
    chk({tag, " valid@+2"}, 32'(bus.o_valid), 32'd1);
    chk({tag, " o_a"}, 32'(bus.o_a), 32'(ea));
    chk({tag, " o_ovf"}, 32'(bus.o_ovf), 32'(eo));
    chk({tag, " o_err"}, 32'(bus.o_err), 32'(ee));
    chk({tag, " o_ch"}, 32'(bus.o_ch), 32'(ch));
    chk({tag, " sat o_a"}, 32'(bus_s.o_a), 32'(es));
    chk({tag, " sat o_ovf"}, 32'(bus_s.o_ovf), 32'(eo));
    $display("op %s: op=%0d ch=%0d a=0x%0h b=0x%0h -> o_a=0x%0h ovf=%0d err=%0d sat=0x%0h",
             tag, op, ch, a, b, bus.o_a, bus.o_ovf, bus.o_err, bus_s.o_a);
  endtask

  // Streams the table back-to-back; i_ready is dropped for stall_len cycles from stall_at.
  task automatic run_stream(input string tag, input int n, input int stall_at, input int stall_len);
    int         idx = 0;
    int         out = 0;
    int         cyc = 0;
    logic       held = 1'b0;
    logic       saw_block = 1'b0;
    logic [7:0] held_a = '0;
    while (out < n && cyc < 200) begin
      @(negedge clk);
      bus.i_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (idx < n) begin
        bus.i_valid = 1'b1; bus.i_op = t_op[idx]; bus.i_ch = t_ch[idx];
        bus.i_a = t_a[idx]; bus.i_b = t_b[idx];
      end else begin
        bus.i_valid = 1'b0;
      end
      #1;
      if (bus.o_valid) begin
        if (held) chk($sformatf("%s hold #%0d", tag, out), 32'(bus.o_a), 32'(held_a));
        if (bus.i_ready) begin
          chk($sformatf("%s o_a #%0d", tag, out), 32'(bus.o_a), 32'(t_ea[out]));
          chk($sformatf("%s o_ovf #%0d", tag, out), 32'(bus.o_ovf), 32'(t_eo[out]));
          chk($sformatf("%s o_err #%0d", tag, out), 32'(bus.o_err), 32'(t_ee[out]));
          chk($sformatf("%s o_ch #%0d", tag, out), 32'(bus.o_ch), 32'(t_ch[out]));
          chk($sformatf("%s sat o_a #%0d", tag, out), 32'(bus_s.o_a), 32'(t_es[out]));
          $display("%s result #%0d: o_a=0x%0h ovf=%0d err=%0d ch=%0d", tag, out,
                   bus.o_a, bus.o_ovf, bus.o_err, bus.o_ch);
          out++;
          held = 1'b0;
        end else begin
          held   = 1'b1;
          held_a = bus.o_a;
        end
      end
      if (!bus.i_ready && !bus.o_ready) saw_block = 1'b1;
      if (bus.i_valid && bus.o_ready) idx++;
      cyc++;
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    chk({tag, " all results"}, 32'(out), 32'(n));
    if (stall_len > 4) chk({tag, " o_ready blocked"}, 32'(saw_block), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    bus.i_op = '0; bus.i_ch = '0; bus.i_a = '0; bus.i_b = '0;
    repeat (2) @(negedge clk);
    chk("rst o_valid", 32'(bus.o_valid), 32'd0);
    chk("rst o_ready", 32'(bus.o_ready), 32'd0);
    chk("rst sat o_ready", 32'(bus_s.o_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post-rst o_ready", 32'(bus.o_ready), 32'd1);
    chk("post-rst o_valid", 32'(bus.o_valid), 32'd0);
    chk("post-rst o_a", 32'(bus.o_a), 32'd0);
    chk("post-rst o_err", 32'(bus.o_err), 32'd0);
    $display("reset released");

    do_op("add127", 2'b00, 2'd0, 8'd100, 8'd27, 8'h7F, 1'b0, 1'b0, 8'h7F);
    do_op("add128", 2'b00, 2'd1, 8'd100, 8'd28, 8'h80, 1'b1, 1'b0, 8'h7F);
    do_op("sub-129", 2'b01, 2'd2, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 8'h80);
    do_op("sub-neg", 2'b01, 2'd0, 8'd5, 8'd9, 8'hFC, 1'b0, 1'b0, 8'hFC);

    // Channel 2 accumulate chain, read-and-clear, then the untouched channels read as 0.
    set_t(0, 2'b10, 2'd2, 8'd5,  8'd0, 8'd5,  1'b0, 1'b0, 8'd5);
    set_t(1, 2'b10, 2'd2, 8'd7,  8'd0, 8'd12, 1'b0, 1'b0, 8'd12);
    set_t(2, 2'b10, 2'd2, 8'hFD, 8'd0, 8'd9,  1'b0, 1'b0, 8'd9);
    set_t(3, 2'b11, 2'd2, 8'd0,  8'd0, 8'd9,  1'b0, 1'b0, 8'd9);
    set_t(4, 2'b10, 2'd2, 8'd1,  8'd0, 8'd1,  1'b0, 1'b0, 8'd1);
    set_t(5, 2'b11, 2'd0, 8'd0,  8'd0, 8'd0,  1'b0, 1'b0, 8'd0);
    set_t(6, 2'b11, 2'd1, 8'd0,  8'd0, 8'd0,  1'b0, 1'b0, 8'd0);
    set_t(7, 2'b11, 2'd2, 8'd0,  8'd0, 8'd1,  1'b0, 1'b0, 8'd1);
    run_stream("acc", 8, 1000, 0);

    // Out-of-range channel on ops 10/11 flags o_err; ops 00/01 never do.
    set_t(0, 2'b10, 2'd0, 8'd4,  8'd0, 8'd4, 1'b0, 1'b0, 8'd4);
    set_t(1, 2'b10, 2'd3, 8'd55, 8'd0, 8'd0, 1'b0, 1'b1, 8'd0);
    set_t(2, 2'b11, 2'd0, 8'd0,  8'd0, 8'd4, 1'b0, 1'b0, 8'd4);
    set_t(3, 2'b11, 2'd3, 8'd0,  8'd0, 8'd0, 1'b0, 1'b1, 8'd0);
    set_t(4, 2'b00, 2'd3, 8'd3,  8'd4, 8'd7, 1'b0, 1'b0, 8'd7);
    run_stream("err", 5, 1000, 0);

    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) set_t(i, 2'b00, 2'(i % 3), 8'(10*i), 8'(i), 8'(11*i), 1'b0, 1'b0, 8'(11*i));
      else            set_t(i, 2'b01, 2'(i % 3), 8'(10*i), 8'(i), 8'(9*i),  1'b0, 1'b0, 8'(9*i));
    end
    run_stream("stall", 10, 3, 5);

    // Fill both stages behind a blocked consumer, then reset mid-flight.
    do_op("acc50", 2'b10, 2'd1, 8'd50, 8'd0, 8'd50, 1'b0, 1'b0, 8'd50);
    @(negedge clk);
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1; bus.i_op = 2'b00; bus.i_ch = 2'd0; bus.i_a = 8'd1; bus.i_b = 8'd1;
    @(negedge clk);
    bus.i_a = 8'd2; bus.i_b = 8'd2;
    #1 chk("fill 2nd ready", 32'(bus.o_ready), 32'd1);
    @(negedge clk);
    bus.i_valid = 1'b0;
    #1;
    chk("full o_ready", 32'(bus.o_ready), 32'd0);
    chk("full o_valid", 32'(bus.o_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-rst o_valid", 32'(bus.o_valid), 32'd0);
    chk("mid-rst o_ready", 32'(bus.o_ready), 32'd0);
    bus.i_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("mid-flight reset released");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk($sformatf("flushed o_valid %0d", i), 32'(bus.o_valid), 32'd0);
    end
    do_op("rd1-after-rst", 2'b11, 2'd1, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish within 200000 time units");
    $fatal(1);
  end
endmodule
